// File: rtl/train_sensor_emulator.sv
// Track-sensor emulator: steps a single active-high pulse around sensors S1..S6 with a
// programmable gap and pulse width. Define SENSOR_BOUNCE_EN to prefix each pulse with a 1,0,1,0 bounce.
module train_sensor_emulator #(
  parameter int INTERVAL_W = 19,
  parameter int PULSE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic [PULSE_W-1:0]    pulse_len,
  input  logic                  direction,
  output logic                  S1,
  output logic                  S2,
  output logic                  S3,
  output logic                  S4,
  output logic                  S5,
  output logic                  S6,
  output logic                  busy,
  output logic [2:0]            sensor_idx,
  output logic                  lap_done
);

  typedef enum logic [1:0] {IDLE, GAP, PULSE} state_t;

  state_t                state_reg, state_next;
  logic [INTERVAL_W-1:0] interval_reg, interval_next;
  logic [PULSE_W-1:0]    pulse_reg, pulse_next;
  logic                  dir_reg, dir_next;
  logic [INTERVAL_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [PULSE_W-1:0]    pulse_cnt_reg, pulse_cnt_next;
  logic [2:0]            nxt_reg, nxt_next;
  logic                  started_reg, started_next;
  logic [5:0]            sensor_reg, sensor_next;
  logic                  busy_reg, busy_next;
  logic [2:0]            idx_reg, idx_next;
  logic                  lap_reg, lap_next;
  logic                  level;
`ifdef SENSOR_BOUNCE_EN
  logic [2:0]            bounce_cnt_reg, bounce_cnt_next;
`endif

  // Next sensor in the selected rotation, wrapping at the ends.
  function automatic logic [2:0] advance(input logic [2:0] cur, input logic rev);
    if (rev) return (cur == 3'd1) ? 3'd6 : cur - 3'd1;
    else     return (cur == 3'd6) ? 3'd1 : cur + 3'd1;
  endfunction

  always_comb begin
    state_next     = state_reg;
    interval_next  = interval_reg;
    pulse_next     = pulse_reg;
    dir_next       = dir_reg;
    gap_cnt_next   = gap_cnt_reg;
    pulse_cnt_next = pulse_cnt_reg;
    nxt_next       = nxt_reg;
    started_next   = started_reg;
    idx_next       = idx_reg;
    lap_next       = 1'b0;
`ifdef SENSOR_BOUNCE_EN
    bounce_cnt_next = bounce_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          interval_next = (interval == '0) ? INTERVAL_W'(1) : interval;
          pulse_next    = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
          dir_next      = direction;
          gap_cnt_next  = (interval == '0) ? INTERVAL_W'(1) : interval;
          nxt_next      = direction ? 3'd6 : 3'd1;
          started_next  = 1'b0;
          state_next    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg <= INTERVAL_W'(1)) begin
          state_next     = PULSE;
          pulse_cnt_next = pulse_reg;
          idx_next       = nxt_reg;
          // The starting sensor comes round again only after a full lap.
          lap_next       = started_reg && (nxt_reg == (dir_reg ? 3'd6 : 3'd1));
          started_next   = 1'b1;
`ifdef SENSOR_BOUNCE_EN
          bounce_cnt_next = 3'd4;
`endif
        end else begin
          gap_cnt_next = gap_cnt_reg - INTERVAL_W'(1);
        end
      end
      PULSE: begin
`ifdef SENSOR_BOUNCE_EN
        if (bounce_cnt_reg != 3'd0) begin
          bounce_cnt_next = bounce_cnt_reg - 3'd1;
        end else
`endif
        if (pulse_cnt_reg <= PULSE_W'(1)) begin
          state_next   = GAP;
          gap_cnt_next = interval_reg;
          nxt_next     = advance(nxt_reg, dir_reg);
        end else begin
          pulse_cnt_next = pulse_cnt_reg - PULSE_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort beats everything else, including a rise scheduled this cycle.
    if (stop) begin
      state_next = IDLE;
      idx_next   = idx_reg;
      lap_next   = 1'b0;
    end
    busy_next = (state_next != IDLE);

`ifdef SENSOR_BOUNCE_EN
    // Bounce counter 4..1 gives 1,0,1,0; zero means solid high.
    level = ~bounce_cnt_next[0];
`else
    level = 1'b1;
`endif
    sensor_next = 6'd0;
    if (state_next == PULSE && level) sensor_next = 6'd1 << (nxt_next - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      interval_reg  <= '0;
      pulse_reg     <= '0;
      dir_reg       <= 1'b0;
      gap_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      nxt_reg       <= 3'd0;
      started_reg   <= 1'b0;
      sensor_reg    <= 6'd0;
      busy_reg      <= 1'b0;
      idx_reg       <= 3'd0;
      lap_reg       <= 1'b0;
`ifdef SENSOR_BOUNCE_EN
      bounce_cnt_reg <= 3'd0;
`endif
    end else begin
      state_reg     <= state_next;
      interval_reg  <= interval_next;
      pulse_reg     <= pulse_next;
      dir_reg       <= dir_next;
      gap_cnt_reg   <= gap_cnt_next;
      pulse_cnt_reg <= pulse_cnt_next;
      nxt_reg       <= nxt_next;
      started_reg   <= started_next;
      sensor_reg    <= sensor_next;
      busy_reg      <= busy_next;
      idx_reg       <= idx_next;
      lap_reg       <= lap_next;
`ifdef SENSOR_BOUNCE_EN
      bounce_cnt_reg <= bounce_cnt_next;
`endif
    end
  end

  assign {S6, S5, S4, S3, S2, S1} = sensor_reg;
  assign busy       = busy_reg;
  assign sensor_idx = idx_reg;
  assign lap_done   = lap_reg;

endmodule

// File: doc/train_sensor_emulator.md
TRAIN_SENSOR_EMULATOR -- requirements
Module: train_sensor_emulator

Interface
REQ-001 Parameter INTERVAL_W, default 19: width of the gap counter and the interval input.
REQ-002 Parameter PULSE_W, default 8: width of the pulse-length input and counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin an emulation run; sampled on clk.
REQ-007 stop  in  1  abort the run; sampled on clk.
REQ-008 interval  in  INTERVAL_W  idle cycles between sensor pulses; latched on accepted start.
REQ-009 pulse_len  in  PULSE_W  cycles each sensor stays high; latched on accepted start.
REQ-010 direction  in  1  0 = S1→S6 order, 1 = S6→S1 order; latched on accepted start.
REQ-011 S1..S6  out  1 each  emulated track-sensor outputs, active-high, registered.
REQ-012 busy  out  1  high while a run is active.
REQ-013 sensor_idx  out  3  number (1..6) of the most recently asserted sensor; 0 = none since reset.
REQ-014 lap_done  out  1  one-cycle pulse on each wrap-around.

Function
REQ-015 FSM states SHALL be IDLE, GAP and PULSE.
REQ-016 IDLE: start=1 and stop=0 → latch interval, pulse_len, direction; load gap counter; go to GAP; busy=1 from the next cycle.
REQ-017 Latched values of 0 SHALL be treated as 1.
REQ-018 GAP: count down the latched interval; on expiry go to PULSE and raise the current sensor.
REQ-019 Timing: start accepted at edge k → first sensor rises at edge k+interval, falls at edge k+interval+pulse_len; the next sensor rises interval cycles after that fall (period = interval+pulse_len).
REQ-020 The first sensor of a run SHALL be S1 (direction=0) or S6 (direction=1).
REQ-021 At most one of S1..S6 SHALL be high in any cycle.
REQ-022 Sequencing wraps S6→S1 (forward) or S1→S6 (reverse). lap_done SHALL pulse in the first cycle of the wrapped sensor's high window, never on the run's first sensor.
REQ-023 sensor_idx SHALL update in the same cycle the sensor rises and SHALL hold its value after stop.
REQ-024 stop=1 in any state SHALL, at the next edge, drive S1..S6=0, busy=0, go to IDLE.
REQ-025 stop wins over start when both are high in the same cycle.
REQ-026 start while busy SHALL be ignored. Changes on interval, pulse_len or direction during a run SHALL be ignored.
REQ-027 A run continues indefinitely until stop or rst.

Reset
REQ-028 rst=1 SHALL, at the next edge, force IDLE, S1..S6=0, busy=0, sensor_idx=0, lap_done=0, and clear all counters and latched values.
REQ-029 rst mid-pulse SHALL drop the active sensor at the same edge. rst SHALL override start and stop.

Configuration
REQ-030 Macro SENSOR_BOUNCE_EN:
- Defined: each PULSE window SHALL begin with a 4-cycle contact-bounce pattern 1,0,1,0 on the selected sensor, followed by pulse_len solid-high cycles. The window lasts pulse_len+4 cycles.
- sensor_idx and lap_done SHALL assert at the first bounce cycle.
- Undefined: clean pulses exactly as REQ-019; no bounce logic synthesized.

Verification
REQ-031 rst, then start with interval=3, pulse_len=2, direction=0 → S1 high edges 3–4, S2 high edges 8–9; busy=1 from edge 1.
REQ-032 interval=1, pulse_len=1, direction=1, run 7 pulses → order S6,S5,S4,S3,S2,S1,S6. lap_done pulses once, with the second S6. sensor_idx ends at 6.
REQ-033 Mid-run S3 high, assert stop → all S low and busy=0 at the next edge; sensor_idx stays 3. start alone in a later cycle restarts the run at S1.
REQ-034 start and stop together in IDLE → no run, busy=0. start while busy with interval=100 → period unchanged.
REQ-035 rst asserted during an S4 pulse → S4=0, sensor_idx=0, busy=0 at the next edge.
REQ-036 SENSOR_BOUNCE_EN defined, interval=2, pulse_len=3 → S1 pattern 1,0,1,0,1,1,1 from edge 2. Checker confirms no other sensor toggles.
